seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_addsub.sv | 27 ++
 rtl/seq_alu.sv | 189 ++++++++++++++++++
 tb/tb_seq_alu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_NOT  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_ADD  = 4'hA;
    localparam logic [3:0] OP_ADC  = 4'hB;
    localparam logic [3:0] OP_SUB  = 4'hC;
    localparam logic [3:0] OP_SBB  = 4'hD;
    localparam logic [3:0] OP_CMP  = 4'hE;
    localparam logic [3:0] OP_LDSR = 4'hF;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_S = 2;
    localparam int unsigned FLG_V = 3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + b + cin, or a - b - cin when sub is set.
module alu_addsub #(
    parameter int unsigned WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] bx;
    logic             cx;
    logic [WIDTH:0]   full;

    // a - b - cin == a + ~b + (1 - cin); carry out of that is the inverted borrow
    assign bx   = sub ? ~b : b;
    assign cx   = cin ^ sub;
    assign full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cx};

    assign sum      = full[WIDTH-1:0];
    assign carry    = full[WIDTH] ^ sub;
    assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, bit-serial shifts/rotates and a
// persistent {V,S,C,Z} status register.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       flags
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH-1:0]   as_b, as_sum;
    logic               as_cin, as_sub, as_carry, as_ovf;

    logic [WIDTH-1:0]   imm_res;
    logic               imm_c, imm_v;
    logic [3:0]         imm_flags;

    logic [WIDTH-1:0]   step_res;
    logic               step_c;

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a       (a),
        .b       (as_b),
        .cin     (as_cin),
        .sub     (as_sub),
        .sum     (as_sum),
        .carry   (as_carry),
        .overflow(as_ovf)
    );

    always_comb begin
        as_b   = b;
        as_cin = 1'b0;
        as_sub = 1'b0;
        case (op)
            OP_INC: begin
                as_b   = '0;
                as_cin = 1'b1;
            end
            OP_DEC: begin
                as_b   = WIDTH'(1);
                as_sub = 1'b1;
            end
            OP_ADC: as_cin = flags_q[FLG_C];
            OP_SUB, OP_CMP: as_sub = 1'b1;
            OP_SBB: begin
                as_sub = 1'b1;
                as_cin = flags_q[FLG_C];
            end
            default: ;
        endcase
    end

    // Single-cycle result, also covers shifts/rotates by zero (C preserved)
    always_comb begin
        imm_res = a;
        imm_c   = 1'b0;
        imm_v   = 1'b0;
        case (op)
            OP_NOT: imm_res = ~a;
            OP_AND: imm_res = a & b;
            OP_OR:  imm_res = a | b;
            OP_XOR: imm_res = a ^ b;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                imm_res = a;
                imm_c   = flags_q[FLG_C];
            end
            OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP: begin
                imm_res = as_sum;
                imm_c   = as_carry;
                imm_v   = as_ovf;
            end
            default: imm_res = a;
        endcase
        if (op == OP_LDSR) begin
            imm_flags = b[3:0];
        end else begin
            imm_flags = {imm_v, imm_res[WIDTH-1], imm_c, imm_res == '0};
        end
    end

    always_comb begin
        step_res = work_q << 1;
        step_c   = work_q[WIDTH-1];
        case (op_q)
            OP_SHR: begin
                step_res = work_q >> 1;
                step_c   = work_q[0];
            end
            OP_ROL: begin
                step_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                step_c   = work_q[WIDTH-1];
            end
            OP_ROR: begin
                step_res = {work_q[0], work_q[WIDTH-1:1]};
                step_c   = work_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        out_data_d = out_data_q;
        flags_d    = flags_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_shift_op(op) && shamt != '0) begin
                        work_d  = a;
                        cnt_d   = shamt;
                        op_d    = op;
                        state_d = StShift;
                    end else begin
                        out_data_d = imm_res;
                        flags_d    = imm_flags;
                        state_d    = StDone;
                    end
                end
            end
            StShift: begin
                work_d = step_res;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    out_data_d = step_res;
                    flags_d    = {1'b0, step_res[WIDTH-1], step_c, step_res == '0};
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            work_q     <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            out_data_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            out_data_q <= out_data_d;
            flags_q    <= flags_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = out_data_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu; flags are shown as {V,S,C,Z}.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'h0;
    logic [19:0] a = '0;
    logic [19:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_data;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    seq_alu #(
        .WIDTH  (20),
        .SHAMT_W(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    // Called at a negedge while idle; scrambles operands after acceptance.
    task automatic issue(input logic [3:0] o, input logic [19:0] aa, input logic [19:0] bb,
                         output int lat);
        in_valid = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op = OP_NOT; a = 20'hAAAAA; b = 20'h55555;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_data !== 20'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 00000", out_data); end
        n_tests++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", flags); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        int lat;
        issue(OP_ADD, 20'hFFFFF, 20'h00001, lat);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", lat); end
        n_tests++; if (out_data !== 20'h00000) begin n_fail++; $display("FAIL add_wrap_data got %h want 00000", out_data); end
        n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL add_wrap_flags got %b want 0011", flags); end
        consume();
        issue(OP_ADC, 20'h00001, 20'h00001, lat);
        n_tests++; if (out_data !== 20'h00003) begin n_fail++; $display("FAIL adc_data got %h want 00003", out_data); end
        n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL adc_flags got %b want 0000", flags); end
        consume();
        issue(OP_ADD, 20'h7FFFF, 20'h00001, lat);
        n_tests++; if (out_data !== 20'h80000) begin n_fail++; $display("FAIL add_ovf_data got %h want 80000", out_data); end
        n_tests++; if (flags !== 4'b1100) begin n_fail++; $display("FAIL add_ovf_flags got %b want 1100", flags); end
        consume();
        issue(OP_SUB, 20'h00005, 20'h00007, lat);
        n_tests++; if (out_data !== 20'hFFFFE) begin n_fail++; $display("FAIL sub_data got %h want FFFFE", out_data); end
        n_tests++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL sub_flags got %b want 0110", flags); end
        consume();
        issue(OP_DEC, 20'h00000, 20'h00000, lat);
        n_tests++; if (out_data !== 20'hFFFFF) begin n_fail++; $display("FAIL dec_data got %h want FFFFF", out_data); end
        n_tests++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL dec_flags got %b want 0110", flags); end
        consume();
    endtask

    task automatic test_logic();
        int lat;
        issue(OP_NOT, 20'h0F0F0, 20'h00000, lat);
        n_tests++; if (out_data !== 20'hF0F0F) begin n_fail++; $display("FAIL not_data got %h want F0F0F", out_data); end
        n_tests++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL not_flags got %b want 0100", flags); end
        consume();
        issue(OP_XOR, 20'h12345, 20'h12345, lat);
        n_tests++; if (out_data !== 20'h00000) begin n_fail++; $display("FAIL xor_data got %h want 00000", out_data); end
        n_tests++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL xor_flags got %b want 0001", flags); end
        consume();
    endtask

    task automatic test_shift();
        int lat;
        int ir_bad;
        in_valid = 1'b1; op = OP_ROL; a = 20'h80001; b = 20'd4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        lat = 1;
        ir_bad = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) ir_bad++;
            @(negedge clk);
            lat++;
        end
        if (in_ready !== 1'b0) ir_bad++;
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL rol_latency got %0d want 5", lat); end
        n_tests++; if (ir_bad !== 0) begin n_fail++; $display("FAIL rol_in_ready_high got %0d want 0", ir_bad); end
        n_tests++; if (out_data !== 20'h00018) begin n_fail++; $display("FAIL rol_data got %h want 00018", out_data); end
        n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rol_flags got %b want 0000", flags); end
        consume();
        issue(OP_SHR, 20'h00003, 20'd1, lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL shr_latency got %0d want 2", lat); end
        n_tests++; if (out_data !== 20'h00001) begin n_fail++; $display("FAIL shr_data got %h want 00001", out_data); end
        n_tests++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL shr_flags got %b want 0010", flags); end
        consume();
        issue(OP_SHL, 20'h00001, 20'd0, lat);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL shl0_latency got %0d want 1", lat); end
        n_tests++; if (out_data !== 20'h00001) begin n_fail++; $display("FAIL shl0_data got %h want 00001", out_data); end
        n_tests++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL shl0_flags_c_kept got %b want 0010", flags); end
        consume();
        issue(OP_SHL, 20'h00001, 20'd25, lat);
        n_tests++; if (lat !== 26) begin n_fail++; $display("FAIL shl25_latency got %0d want 26", lat); end
        n_tests++; if (out_data !== 20'h00000) begin n_fail++; $display("FAIL shl25_data got %h want 00000", out_data); end
        n_tests++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL shl25_flags got %b want 0001", flags); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int unstable;
        issue(OP_CMP, 20'h12345, 20'h12345, lat);
        in_valid = 1'b1; op = OP_INC; a = 20'h00005; b = 20'h00000;
        unstable = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b1 || out_data !== 20'h0 || flags !== 4'b0001 || in_ready !== 1'b0)
                unstable++;
            @(negedge clk);
        end
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL cmp_hold_unstable got %0d want 0", unstable); end
        n_tests++; if (out_data !== 20'h0) begin n_fail++; $display("FAIL cmp_data got %h want 00000", out_data); end
        n_tests++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL cmp_flags got %b want 0001", flags); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_req_valid got %b want 1", out_valid); end
        n_tests++; if (out_data !== 20'h00006) begin n_fail++; $display("FAIL bp_held_req_data got %h want 00006", out_data); end
        consume();
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        issue(OP_LDSR, 20'h00042, 20'h00005, lat);
        n_tests++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL ldsr5_flags got %b want 0101", flags); end
        consume();
        in_valid = 1'b1; op = OP_ROR; a = 20'h12345; b = 20'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL abort_flags got %b want 0000", flags); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result got %0d want 0", seen); end
        issue(OP_LDSR, 20'h0BEEF, 20'h0000A, lat);
        n_tests++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL ldsr_flags got %b want 1010", flags); end
        n_tests++; if (out_data !== 20'h0BEEF) begin n_fail++; $display("FAIL ldsr_data got %h want 0BEEF", out_data); end
        consume();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_backpressure();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
